// File: rtl/seg_pkg.sv
// ============================================================================
// seg_pkg : shared constants, types and helpers for the 7-segment capture path
// Revision: 1.0
// ============================================================================
`default_nettype none

package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = 2;

  // Active-low patterns, bit 6 = g ... bit 0 = a
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h58;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } dwell_state_t;

  typedef struct packed {
    logic       is_hex;
    logic       is_blank;
    logic [3:0] nibble;
  } seg_dec_t;

  function automatic logic an_one_hot(input logic [NUM_DIGITS-1:0] an);
    return (an == 4'b1110) || (an == 4'b1101) ||
           (an == 4'b1011) || (an == 4'b0111);
  endfunction

  function automatic logic [IDX_W-1:0] an_index(input logic [NUM_DIGITS-1:0] an);
    logic [IDX_W-1:0] idx;
    case (an)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_capture_if.sv
// ============================================================================
// seg_capture_if : display pin bundle and decoded readback of seg_capture
// Revision: 1.0
// ============================================================================
`default_nettype none

interface seg_capture_if;
  import seg_pkg::*;

  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              segs;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   valid;
  logic [NUM_DIGITS-1:0]   err;
  logic                    upd;
  logic [IDX_W-1:0]        upd_idx;

  modport master (
    output an, segs,
    input  digits, valid, err, upd, upd_idx
  );

  modport slave (
    input  an, segs,
    output digits, valid, err, upd, upd_idx
  );

endinterface

`default_nettype wire

// File: rtl/seg_decode.sv
// ============================================================================
// seg_decode : active-low 7-segment pattern to hex nibble / blank classifier
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg_decode
  import seg_pkg::*;
(
  input  logic [6:0] segs,
  output seg_dec_t   dec
);

  always_comb begin
    dec.is_hex   = 1'b1;
    dec.is_blank = 1'b0;
    dec.nibble   = 4'h0;
    case (segs)
      SEG_0:     dec.nibble = 4'h0;
      SEG_1:     dec.nibble = 4'h1;
      SEG_2:     dec.nibble = 4'h2;
      SEG_3:     dec.nibble = 4'h3;
      SEG_4:     dec.nibble = 4'h4;
      SEG_5:     dec.nibble = 4'h5;
      SEG_6:     dec.nibble = 4'h6;
      SEG_7:     dec.nibble = 4'h7;
      SEG_8:     dec.nibble = 4'h8;
      SEG_9:     dec.nibble = 4'h9;
      SEG_A:     dec.nibble = 4'hA;
      SEG_B:     dec.nibble = 4'hB;
      SEG_C:     dec.nibble = 4'hC;
      SEG_D:     dec.nibble = 4'hD;
      SEG_E:     dec.nibble = 4'hE;
      SEG_F:     dec.nibble = 4'hF;
      SEG_BLANK: begin
        dec.is_hex   = 1'b0;
        dec.is_blank = 1'b1;
      end
      default:   dec.is_hex = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg_capture.sv
// ============================================================================
// seg_capture : synchronizes a muxed 7-segment bus, waits for each digit to
//               settle and holds the decoded 16-bit readback with flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg_capture
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         rst_n,
  seg_capture_if.slave bus
);

  localparam int             CNT_W     = $clog2(STABLE_CYCLES + 1);
  localparam int             TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_STABLE  = CNT_W'(STABLE_CYCLES);
  localparam logic [TO_W-1:0]  c_TO_MAX  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]  c_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [NUM_DIGITS-1:0]   r_an_s1, r_an_s2;
  logic [6:0]              r_segs_s1, r_segs_s2;
  dwell_state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt, w_cnt_inc;
  logic                    w_capture, w_changed, w_one_hot;
  logic [IDX_W-1:0]        w_idx;
  seg_dec_t                w_dec;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_valid, r_err;
  logic                    r_upd;
  logic [IDX_W-1:0]        r_upd_idx;
  logic [TO_W-1:0]         r_tcnt [NUM_DIGITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an_s1   <= '1;
      r_an_s2   <= '1;
      r_segs_s1 <= '1;
      r_segs_s2 <= '1;
    end else begin
      r_an_s1   <= bus.an;
      r_an_s2   <= r_an_s1;
      r_segs_s1 <= bus.segs;
      r_segs_s2 <= r_segs_s1;
    end
  end

  // Stage 1 is the sample stage 2 takes next, so comparing them lets the
  // counter track the synchronized value without an extra cycle of latency.
  assign w_changed = {r_an_s1, r_segs_s1} != {r_an_s2, r_segs_s2};
  assign w_one_hot = an_one_hot(r_an_s1);
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_idx     = an_index(r_an_s2);

  seg_decode u_decode (
    .segs (r_segs_s2),
    .dec  (w_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_WAIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    if (!w_one_hot) begin
      w_state_nxt = ST_WAIT;
      w_cnt_nxt   = '0;
    end else if (w_changed || (r_state == ST_WAIT)) begin
      w_state_nxt = ST_COUNT;
      w_cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (r_state == ST_COUNT) begin
      w_cnt_nxt = w_cnt_inc;
      if (w_cnt_inc == c_STABLE) begin
        w_capture   = 1'b1;
        w_state_nxt = ST_DONE;
      end
    end
  end

  // A capture on a digit takes priority over that digit's timeout expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits  <= '0;
      r_valid   <= '0;
      r_err     <= '0;
      r_upd     <= 1'b0;
      r_upd_idx <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) r_tcnt[i] <= '0;
    end else begin
      r_upd <= w_capture;
      if (w_capture) r_upd_idx <= w_idx;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_capture && (w_idx == IDX_W'(i))) begin
          r_tcnt[i] <= '0;
          if (w_dec.is_hex) begin
            r_digits[4*i +: 4] <= w_dec.nibble;
            r_valid[i]         <= 1'b1;
            r_err[i]           <= 1'b0;
          end else begin
            r_valid[i] <= 1'b0;
            r_err[i]   <= !w_dec.is_blank;
          end
        end else if (r_tcnt[i] != c_TO_MAX) begin
          r_tcnt[i] <= r_tcnt[i] + 1'b1;
          if (r_tcnt[i] == c_TO_LAST) r_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.digits  = r_digits;
  assign bus.valid   = r_valid;
  assign bus.err     = r_err;
  assign bus.upd     = r_upd;
  assign bus.upd_idx = r_upd_idx;

endmodule

`default_nettype wire

// File: tb/tb_seg_capture.sv
// ============================================================================
// tb_seg_capture : randomized and directed bench with a run-length pin model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seg_capture;

  localparam int STABLE = 4;
  localparam int TO_A   = 1000000;
  localparam int TO_B   = 100;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg_capture_if bus_a ();
  seg_capture_if bus_b ();

  seg_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TO_A)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  seg_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TO_B)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  localparam logic [6:0] PAT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                      7'h02, 7'h58, 7'h00, 7'h10, 7'h08, 7'h03,
                                      7'h46, 7'h21, 7'h06, 7'h0E};

  int n_err = 0;
  int n_chk = 0;

  logic [10:0] m_last;
  int          m_run;
  int          edge_no = 0;
  logic [3:0]  m_dig [4];
  bit          m_val [2][4];
  bit          m_errf [4];
  bit          m_upd;
  int          m_idx;
  int          m_cap_edge [4];
  int          obs_upd_a = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // 0..15 hex, 16 blank, 17 undecodable
  function automatic int decode(input logic [6:0] s);
    for (int k = 0; k < 16; k++) if (PAT[k] == s) return k;
    if (s == 7'h7F) return 16;
    return 17;
  endfunction

  function automatic int low_idx(input logic [3:0] an);
    int zeros = 0;
    int pos   = -1;
    for (int k = 0; k < 4; k++) if (!an[k]) begin zeros++; pos = k; end
    return (zeros == 1) ? pos : -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_dig[i] = 4'h0; m_val[0][i] = 0; m_val[1][i] = 0; m_errf[i] = 0;
      m_cap_edge[i] = edge_no;
    end
    m_upd = 0; m_idx = 0; m_last = '1; m_run = 0;
  endtask

  // A pin value present at edge k reaches the decoder on edge k+1; a capture
  // happens once a one-hot run of identical pin values is STABLE long.
  task automatic model_edge(input logic [10:0] p);
    int idx, d;
    edge_no++;
    m_upd = 0;
    if (!rst_n) begin
      m_last = '1; m_run = 0;
      return;
    end
    idx = low_idx(m_last[10:7]);
    if (idx >= 0 && m_run == STABLE) begin
      d = decode(m_last[6:0]);
      m_upd = 1; m_idx = idx; m_cap_edge[idx] = edge_no;
      if (d < 16) begin
        m_dig[idx] = d[3:0]; m_val[0][idx] = 1; m_val[1][idx] = 1; m_errf[idx] = 0;
      end else begin
        m_val[0][idx] = 0; m_val[1][idx] = 0; m_errf[idx] = (d == 17);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (edge_no - m_cap_edge[i] == TO_A) m_val[0][i] = 0;
      if (edge_no - m_cap_edge[i] == TO_B) m_val[1][i] = 0;
    end
    if (p == m_last) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_run = 1;
    end
    m_last = p;
  endtask

  task automatic compare_all();
    logic [15:0] ed;
    logic [3:0]  ev_a, ev_b, ee;
    for (int i = 0; i < 4; i++) begin
      ed[4*i +: 4] = m_dig[i];
      ev_a[i] = m_val[0][i]; ev_b[i] = m_val[1][i]; ee[i] = m_errf[i];
    end
    if (bus_a.upd) obs_upd_a++;
    check("a.digits",  32'(bus_a.digits),  32'(ed));
    check("a.valid",   32'(bus_a.valid),   32'(ev_a));
    check("a.err",     32'(bus_a.err),     32'(ee));
    check("a.upd",     32'(bus_a.upd),     32'(m_upd));
    check("a.upd_idx", 32'(bus_a.upd_idx), 32'(m_idx));
    check("b.digits",  32'(bus_b.digits),  32'(ed));
    check("b.valid",   32'(bus_b.valid),   32'(ev_b));
    check("b.err",     32'(bus_b.err),     32'(ee));
    check("b.upd",     32'(bus_b.upd),     32'(m_upd));
    check("b.upd_idx", 32'(bus_b.upd_idx), 32'(m_idx));
  endtask

  // Called #1 after a rising edge: pins settle well before the next edge.
  task automatic tick(input logic [3:0] an, input logic [6:0] segs);
    bus_a.an = an; bus_a.segs = segs;
    bus_b.an = an; bus_b.segs = segs;
    @(posedge clk);
    model_edge({an, segs});
    #1;
    compare_all();
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] segs, input int n);
    repeat (n) tick(an, segs);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst.a_digits", 32'(bus_a.digits), 32'h0);
    check("rst.a_valid",  32'(bus_a.valid),  32'h0);
    check("rst.a_err",    32'(bus_a.err),    32'h0);
    check("rst.a_upd",    32'(bus_a.upd),    32'h0);
    check("rst.a_idx",    32'(bus_a.upd_idx), 32'h0);
    check("rst.b_digits", 32'(bus_b.digits), 32'h0);
    check("rst.b_valid",  32'(bus_b.valid),  32'h0);
    model_reset();
    hold(4'hF, 7'h7F, 2);
    rst_n = 1'b1;
  endtask

  int base;

  initial begin
    rst_n = 1'b0;
    bus_a.an = '1; bus_a.segs = '1;
    bus_b.an = '1; bus_b.segs = '1;
    model_reset();
    @(posedge clk); #1;
    apply_reset();

    base = obs_upd_a;
    hold(4'b1110, 7'h30, 10);
    check("single.upd_cnt", 32'(obs_upd_a - base), 32'd1);
    check("single.digit0",  32'(bus_a.digits[3:0]), 32'h3);
    check("single.valid",   32'(bus_a.valid), 32'b0001);
    check("single.err",     32'(bus_a.err),   32'b0000);

    base = obs_upd_a;
    hold(4'b1110, 7'h0E, 50);
    hold(4'b1101, 7'h21, 50);
    hold(4'b1011, 7'h46, 50);
    hold(4'b0111, 7'h03, 50);
    check("scan.upd_cnt", 32'(obs_upd_a - base), 32'd4);
    check("scan.digits",  32'(bus_a.digits), 32'hBCDF);
    check("scan.valid",   32'(bus_a.valid),  32'hF);

    hold(4'b1101, 7'h55, 10);
    check("inv.err1",   32'(bus_a.err[1]),     32'd1);
    check("inv.valid1", 32'(bus_a.valid[1]),   32'd0);
    check("inv.digit1", 32'(bus_a.digits[7:4]), 32'hD);
    hold(4'b1101, 7'h7F, 10);
    check("blank.err1",   32'(bus_a.err[1]),   32'd0);
    check("blank.valid1", 32'(bus_a.valid[1]), 32'd0);

    hold(4'b1110, 7'h40, 20);
    base = obs_upd_a;
    hold(4'b1011, 7'h00, 3);
    hold(4'b1110, 7'h40, 20);
    check("glitch.upd_cnt", 32'(obs_upd_a - base), 32'd1);
    check("glitch.digit2",  32'(bus_a.digits[11:8]), 32'hC);
    check("glitch.idx",     32'(bus_a.upd_idx), 32'd0);

    base = obs_upd_a;
    hold(4'b0011, 7'h30, 20);
    check("twolow.upd_cnt", 32'(obs_upd_a - base), 32'd0);

    hold(4'b0111, 7'h10, 10);
    hold(4'b1111, 7'h7F, 120);
    check("tmo.b_valid3", 32'(bus_b.valid[3]),      32'd0);
    check("tmo.b_digit3", 32'(bus_b.digits[15:12]), 32'h9);
    check("tmo.a_valid3", 32'(bus_a.valid[3]),      32'd1);

    hold(4'b1110, 7'h12, 2);
    apply_reset();
    base = obs_upd_a;
    hold(4'b1110, 7'h12, 3);
    check("postrst.upd_cnt", 32'(obs_upd_a - base), 32'd0);
    hold(4'b1110, 7'h12, 5);

    for (int n = 0; n < 400; n++) begin
      logic [3:0] an;
      logic [6:0] sg;
      int sel;
      an = ~(4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) an = 4'($urandom);
      sel = $urandom_range(0, 19);
      if (sel < 16)       sg = PAT[sel];
      else if (sel < 18)  sg = 7'h7F;
      else                sg = 7'($urandom);
      hold(an, sg, $urandom_range(1, 8));
      if ($urandom_range(0, 39) == 0) hold(4'hF, 7'h7F, $urandom_range(90, 130));
      if ($urandom_range(0, 99) == 0) apply_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
